// File: rtl/noise_ctrl_pkg.sv
// Shared FSM states, source codes and shadow-config reset values
// for the noise injection controller.
package noise_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    localparam logic [2:0] SRC_PRBS  = 3'd0;
    localparam logic [2:0] SRC_TRI   = 3'd1;
    localparam logic [2:0] SRC_SUM   = 3'd2;
    localparam logic [2:0] SRC_GAUSS = 3'd3;
    localparam logic [2:0] SRC_WHITE = 3'd4;
    localparam logic [2:0] SRC_PINK  = 3'd5;
    localparam logic [2:0] SRC_ATM   = 3'd6;
    localparam logic [2:0] SRC_NONE  = 3'd7;

    localparam logic [2:0]  RST_SRC     = SRC_NONE;
    localparam logic [4:0]  RST_SHIFT   = 5'd0;
    localparam int unsigned RST_ON_LEN  = 1;
    localparam int unsigned RST_OFF_LEN = 0;
    localparam int unsigned RST_BURSTS  = 1;

endpackage

// File: rtl/noise_src_mux.sv
// Source select, arithmetic attenuation and optional clamp.
// Clamp present only when NOISE_CLIP_EN is defined.
module noise_src_mux
    import noise_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   sel,
    input  logic [4:0]   shift,
    input  logic [W-1:0] src_prbs,
    input  logic [W-1:0] src_tri,
    input  logic [W-1:0] src_sum,
    input  logic [W-1:0] src_gauss,
    input  logic [W-1:0] src_white,
    input  logic [W-1:0] src_pink,
    input  logic [W-1:0] src_atm,
`ifdef NOISE_CLIP_EN
    input  logic [W-2:0] clip,
`endif
    output logic [W-1:0] y
);

    logic signed [W-1:0] raw;
    logic signed [W-1:0] shifted;

    always_comb begin
        raw = '0;
        unique case (sel)
            SRC_PRBS:  raw = src_prbs;
            SRC_TRI:   raw = src_tri;
            SRC_SUM:   raw = src_sum;
            SRC_GAUSS: raw = src_gauss;
            SRC_WHITE: raw = src_white;
            SRC_PINK:  raw = src_pink;
            SRC_ATM:   raw = src_atm;
            SRC_NONE:  raw = '0;
        endcase
        shifted = raw >>> shift;
    end

`ifdef NOISE_CLIP_EN
    logic signed [W-1:0] lim;
    assign lim = $signed({1'b0, clip});

    always_comb begin
        y = shifted;
        if (shifted > lim)
            y = lim;
        else if (shifted < -lim)
            y = -lim;
    end
`else
    assign y = shifted;
`endif

endmodule

// File: rtl/noise_inject_ctrl.sv
// Burst-gated noise injection controller (FSM, counters, output reg).
// Optional clamp port cfg_clip is enabled by NOISE_CLIP_EN.
module noise_inject_ctrl
    import noise_ctrl_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 32,
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [2:0]    cfg_src,
    input  logic [4:0]    cfg_shift,
    input  logic [CW-1:0] cfg_on_len,
    input  logic [CW-1:0] cfg_off_len,
    input  logic [BW-1:0] cfg_bursts,
`ifdef NOISE_CLIP_EN
    input  logic [W-2:0]  cfg_clip,
`endif
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  src_prbs,
    input  logic [W-1:0]  src_tri,
    input  logic [W-1:0]  src_sum,
    input  logic [W-1:0]  src_gauss,
    input  logic [W-1:0]  src_white,
    input  logic [W-1:0]  src_pink,
    input  logic [W-1:0]  src_atm,
    output logic [W-1:0]  noise_out,
    output logic          noise_valid,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] burst_cnt
);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [BW-1:0] bcnt, bcnt_d, bcnt_inc;
    logic          on_last, off_last;
    logic [W-1:0]  mux_y;

    logic [2:0]    sh_src;
    logic [4:0]    sh_shift;
    logic [CW-1:0] sh_on, sh_off;
    logic [BW-1:0] sh_bursts;
`ifdef NOISE_CLIP_EN
    logic [W-2:0]  sh_clip;
`endif

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_ARM) || (state == S_ON) || (state == S_OFF);
    assign done      = (state == S_DONE);
    assign burst_cnt = bcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_src    <= RST_SRC;
            sh_shift  <= RST_SHIFT;
            sh_on     <= CW'(RST_ON_LEN);
            sh_off    <= CW'(RST_OFF_LEN);
            sh_bursts <= BW'(RST_BURSTS);
`ifdef NOISE_CLIP_EN
            sh_clip   <= '1;
`endif
        end else if (cfg_valid && cfg_ready) begin
            sh_src    <= cfg_src;
            sh_shift  <= cfg_shift;
            sh_on     <= cfg_on_len;
            sh_off    <= cfg_off_len;
            sh_bursts <= cfg_bursts;
`ifdef NOISE_CLIP_EN
            sh_clip   <= cfg_clip;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            bcnt  <= bcnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        bcnt_d   = bcnt;
        bcnt_inc = (&bcnt) ? bcnt : bcnt + BW'(1);
        on_last  = (sh_on <= CW'(1)) || (cnt == sh_on - CW'(1));
        off_last = (sh_off <= CW'(1)) || (cnt == sh_off - CW'(1));
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end
            end
            S_ARM: state_d = S_ON;
            S_ON: begin
                if (on_last) begin
                    cnt_d  = '0;
                    bcnt_d = bcnt_inc;
                    if (sh_bursts != '0 && bcnt_inc == sh_bursts)
                        state_d = S_DONE;
                    else if (sh_off == '0)
                        state_d = S_ON;
                    else
                        state_d = S_OFF;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_OFF: begin
                if (off_last) begin
                    cnt_d   = '0;
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // stop freezes the counters so burst_cnt reports what was completed
        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = cnt;
            bcnt_d  = bcnt;
        end
    end

    noise_src_mux #(.W(W)) u_mux (
        .sel       (sh_src),
        .shift     (sh_shift),
        .src_prbs  (src_prbs),
        .src_tri   (src_tri),
        .src_sum   (src_sum),
        .src_gauss (src_gauss),
        .src_white (src_white),
        .src_pink  (src_pink),
        .src_atm   (src_atm),
`ifdef NOISE_CLIP_EN
        .clip      (sh_clip),
`endif
        .y         (mux_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noise_out   <= '0;
            noise_valid <= 1'b0;
        end else if (state == S_ON && !stop) begin
            noise_out   <= mux_y;
            noise_valid <= 1'b1;
        end else begin
            noise_out   <= '0;
            noise_valid <= 1'b0;
        end
    end

endmodule

// File: doc/noise_inject_ctrl.md
NOISE_INJECT_CTRL -- requirements
Module: noise_inject_ctrl

Interface
REQ-001 Parameter W, default 32: signed sample width of every noise source and of noise_out.
REQ-002 Parameter CW, default 32: width of the on/off duration counters.
REQ-003 Parameter BW, default 16: width of the burst counter.
REQ-004 clk  in  1  single clock; every register updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cfg_valid  in  1  configuration offered; cfg_ready  out  1  configuration accepted when both are high.
REQ-007 cfg_src  in  3  source select: 0 PRBS, 1 triangle, 2 sum, 3 gaussian, 4 white, 5 pink, 6 atm, 7 none.
REQ-008 cfg_shift  in  5  arithmetic right-shift (attenuation) applied to the selected source.
REQ-009 cfg_on_len, cfg_off_len  in  CW each  burst on/off durations in cycles; cfg_bursts  in  BW  burst count, 0 = endless.
REQ-010 start, stop  in  1 each  single-cycle command pulses.
REQ-011 src_prbs, src_tri, src_sum, src_gauss, src_white, src_pink, src_atm  in  W each  signed source samples.
REQ-012 noise_out  out  W  signed injected noise; noise_valid  out  1  high while noise_out carries source data.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); burst_cnt  out  BW  completed bursts.

Function
REQ-014 The FSM SHALL have the states IDLE, ARM, ON, OFF and DONE.
REQ-015 cfg_ready SHALL be high only in IDLE; an accepted configuration is latched into shadow registers, and cfg_valid outside IDLE is held unaccepted.
REQ-016 start in IDLE SHALL go to ARM, clear burst_cnt and the duration counter, then go to ON on the next cycle; start outside IDLE is ignored.
REQ-017 In ON, noise_out SHALL be the selected source >>> shift, registered with 1-cycle latency, and noise_valid SHALL be 1.
REQ-018 A cfg_src of 7 SHALL drive noise_out to 0 with noise_valid still 1.
REQ-019 ON SHALL last max(cfg_on_len,1) cycles; on exit, burst_cnt increments, saturating at all-ones.
REQ-020 After ON, a completed burst count (cfg_bursts != 0 and burst_cnt == cfg_bursts after the increment) SHALL go to DONE; otherwise cfg_off_len == 0 re-enters ON directly, and any other value enters OFF.
REQ-021 OFF SHALL last cfg_off_len cycles with noise_out = 0 and noise_valid = 0, then return to ON.
REQ-022 DONE SHALL last one cycle, assert done for that cycle, then return to IDLE.
REQ-023 stop SHALL force IDLE on the next edge from any state, with noise_out = 0 and noise_valid = 0 from that edge and no done pulse.
REQ-024 stop and start in the same cycle SHALL be treated as stop.
REQ-025 busy SHALL be high in ARM, ON and OFF.
REQ-026 burst_cnt SHALL hold its value in IDLE until the next start.

Reset
REQ-027 While rst is low, the block SHALL be in IDLE with all outputs 0 except cfg_ready = 1.
REQ-028 Reset SHALL clear the shadow configuration to src 7, shift 0, on_len 1, off_len 0 and bursts 1.
REQ-029 Reset mid-burst SHALL abort immediately, with no done pulse.

Configuration
REQ-030 With NOISE_CLIP_EN defined, the block SHALL add a port cfg_clip (in, W-1, unsigned, latched with the configuration) and clamp the shifted sample to [-cfg_clip, +cfg_clip] before the output register.
REQ-031 With NOISE_CLIP_EN defined, the clamp SHALL add no latency.
REQ-032 Without NOISE_CLIP_EN, the cfg_clip port and the clamp logic SHALL be absent.

Structure
REQ-033 Package noise_ctrl_pkg SHALL hold the FSM state enum, the source-code constants (SRC_PRBS to SRC_NONE) and the reset defaults of the shadow configuration.
REQ-034 A sub-module noise_src_mux SHALL hold the source select, the shift and the optional clamp; the FSM, counters and output register stay in noise_inject_ctrl.

Verification
REQ-035 Configure src 3, shift 4, on_len 5, off_len 3, bursts 2, then start -> ARM 1 cycle; noise_valid high 5 cycles, low 3, high 5; done 1 cycle later; burst_cnt = 2.
REQ-036 Constant src_white = -1600 with src 4, shift 4 -> noise_out = -100, lagging its ON entry by 1 cycle.
REQ-037 bursts 0, on_len 2, off_len 0 -> noise_valid stays high continuously and burst_cnt increments every 2 cycles; a stop pulse -> noise_valid and noise_out = 0 next cycle, no done.
REQ-038 start and stop in the same IDLE cycle -> stays IDLE and busy = 0; cfg_valid during ON -> cfg_ready = 0 until IDLE, then accepted.
REQ-039 rst low during OFF of burst 1 of 3 -> IDLE, outputs 0, cfg_ready = 1, no done.
REQ-040 NOISE_CLIP_EN with cfg_clip = 50 and src_gauss = +1000, shift 0 -> noise_out = +50; src_gauss = -1000 -> noise_out = -50.
